// File: rtl/adder_operand_loader.sv
// Operand loader / result register wrapper around an untimed WIDTH-bit ripple adder.
// Optional signed-overflow output is enabled with the ADDER_LOADER_OVF_EN macro.
module adder_operand_loader #(
  parameter int WIDTH = 100,
  parameter int CHUNK = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHUNK-1:0] in_data,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("adder_operand_loader: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_add_cin;
  logic [WIDTH-1:0] r_res_sum;
  logic             r_res_cout;
  logic             r_res_valid;
  logic             r_in_ready;
`ifdef ADDER_LOADER_OVF_EN
  logic             r_res_ovf;
`endif

  logic w_beat;
  logic w_res_xfer;

  assign w_beat     = in_valid & r_in_ready;
  assign w_res_xfer = r_res_valid & res_ready;

  // Operand collection, adder settle cycle and result hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD_A;
      r_cnt       <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_cin   <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_valid <= 1'b0;
      r_in_ready  <= 1'b0;
`ifdef ADDER_LOADER_OVF_EN
      r_res_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        LOAD_A: begin
          r_in_ready <= 1'b1;
          if (w_beat) begin
            r_add_a[r_cnt*CHUNK +: CHUNK] <= in_data;
            if (r_cnt == '0) begin
              r_add_cin <= in_cin;
            end
            if (r_cnt == LAST_BEAT) begin
              r_cnt   <= '0;
              r_state <= LOAD_B;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        LOAD_B: begin
          if (w_beat) begin
            r_add_b[r_cnt*CHUNK +: CHUNK] <= in_data;
            if (r_cnt == LAST_BEAT) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= COMPUTE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        // Adder outputs have had a full cycle to ripple from the final B beat.
        COMPUTE: begin
          r_res_sum   <= add_sum;
          r_res_cout  <= add_cout;
`ifdef ADDER_LOADER_OVF_EN
          r_res_ovf   <= (r_add_a[WIDTH-1] == r_add_b[WIDTH-1]) &
                         (add_sum[WIDTH-1] != r_add_a[WIDTH-1]);
`endif
          r_res_valid <= 1'b1;
          r_state     <= RESULT;
        end
        RESULT: begin
          if (w_res_xfer) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= LOAD_A;
          end
        end
        default: begin
          r_state     <= LOAD_A;
          r_cnt       <= '0;
          r_res_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;
  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_cout  = r_res_cout;
`ifdef ADDER_LOADER_OVF_EN
  assign res_ovf   = r_res_ovf;
`else
  assign res_ovf   = 1'b0;
`endif

endmodule
